// File: rtl/gshare_pht.sv
// gshare_pht: gshare pattern history table of 2-bit saturating counters with history handoff and mispredict count
module gshare_pht #(
  parameter int GHR_W = 3,
  parameter int PC_W = 8,
  parameter int CNT_W = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_en,
  input  logic [PC_W-1:0]  lookup_pc,
  input  logic [GHR_W-1:0] ghr_in,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_idx,
  input  logic             upd_en,
  input  logic [GHR_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             ghr_update_en,
  output logic             ghr_in_bit,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int N = 1 << GHR_W;
  logic [1:0]       tbl_q [N];
  logic [1:0]       tbl_d [N];
  logic [1:0]       cur;
  logic [GHR_W-1:0] idx;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [GHR_W-1:0] pred_idx_q, pred_idx_d;
  logic             ghr_update_en_q, ghr_update_en_d;
  logic             ghr_in_bit_q, ghr_in_bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_pc;
  assign unused_pc = ^lookup_pc;
  assign idx = lookup_pc[GHR_W+1:2] ^ ghr_in;
  assign cur = tbl_q[upd_idx];
  // Lookup reads the pre-update table, so a same-index update in the same cycle is read-before-write
  always_comb begin
    tbl_d = tbl_q;
    if (upd_en) tbl_d[upd_idx] = upd_taken ? ((cur == 2'b11) ? cur : cur + 2'b01) : ((cur == 2'b00) ? cur : cur - 2'b01);
    pred_valid_d = lookup_en;
    pred_taken_d = lookup_en ? tbl_q[idx][1] : pred_taken_q;
    pred_idx_d = lookup_en ? idx : pred_idx_q;
    ghr_update_en_d = upd_en;
    ghr_in_bit_d = upd_en ? upd_taken : ghr_in_bit_q;
    cnt_d = (upd_en && (upd_pred != upd_taken) && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  // State registers; async reset drops any in-flight lookup or training
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= INIT_CTR;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q <= '0;
      ghr_update_en_q <= 1'b0;
      ghr_in_bit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q <= pred_idx_d;
      ghr_update_en_q <= ghr_update_en_d;
      ghr_in_bit_q <= ghr_in_bit_d;
      cnt_q <= cnt_d;
    end
  end
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx = pred_idx_q;
  assign ghr_update_en = ghr_update_en_q;
  assign ghr_in_bit = ghr_in_bit_q;
  assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_gshare_pht.sv
// tb_gshare_pht: random and directed check of gshare_pht against an integer-level reference model
module tb_gshare_pht;
  logic clk = 0, reset = 0, lookup_en = 0, upd_en = 0, upd_taken = 0, upd_pred = 0;
  logic [7:0] lookup_pc = 0;
  logic [2:0] ghr_in = 0, upd_idx = 0;
  logic pred_valid, pred_taken, ghr_update_en, ghr_in_bit;
  logic [2:0] pred_idx;
  logic [15:0] cnt;
  logic s_valid, s_taken, s_gu, s_gb;
  logic [2:0] s_idx;
  logic [1:0] s_cnt;
  logic [2:0] hist;
  int checks = 0, errors = 0;
  bit cmp_en = 0;
  int tbl [8];
  int m_valid, m_taken, m_idx, m_gu, m_gb, m_cnt, m_cnt2, li;

  gshare_pht dut (
    .clk(clk), .reset(reset), .lookup_en(lookup_en), .lookup_pc(lookup_pc), .ghr_in(ghr_in),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr_update_en(ghr_update_en), .ghr_in_bit(ghr_in_bit), .mispredict_cnt(cnt)
  );

  gshare_pht #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .lookup_en(lookup_en), .lookup_pc(lookup_pc), .ghr_in(ghr_in),
    .pred_valid(s_valid), .pred_taken(s_taken), .pred_idx(s_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr_update_en(s_gu), .ghr_in_bit(s_gb), .mispredict_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as integers 0..3, taken when value >= 2
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (tbl[i]) tbl[i] = 1;
      m_valid = 0; m_taken = 0; m_idx = 0; m_gu = 0; m_gb = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_valid = lookup_en;
      if (lookup_en) begin
        li = ((int'(lookup_pc) / 4) % 8) ^ int'(ghr_in);
        m_idx = li;
        m_taken = (tbl[li] >= 2);
      end
      m_gu = upd_en;
      if (upd_en) begin
        m_gb = upd_taken;
        tbl[upd_idx] = upd_taken ? ((tbl[upd_idx] < 3) ? tbl[upd_idx] + 1 : 3) : ((tbl[upd_idx] > 0) ? tbl[upd_idx] - 1 : 0);
        if (upd_pred != upd_taken) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
  end

  // External 3-bit history register fed by the handoff outputs
  always @(posedge clk or negedge reset)
    if (!reset) hist <= 0;
    else if (ghr_update_en) hist <= {hist[1:0], ghr_in_bit};

  always @(negedge clk) if (cmp_en) begin
    chk("pred_valid", pred_valid, m_valid);
    chk("pred_taken", pred_taken, m_taken);
    chk("pred_idx", pred_idx, m_idx);
    chk("ghr_update_en", ghr_update_en, m_gu);
    chk("ghr_in_bit", ghr_in_bit, m_gb);
    chk("mispredict_cnt", cnt, m_cnt);
    chk("mispredict_cnt2", s_cnt, m_cnt2);
  end

  task automatic step(input bit le, input logic [7:0] pc, input logic [2:0] g, input bit ue, input logic [2:0] ui, input bit ut, input bit up);
    @(negedge clk);
    lookup_en = le; lookup_pc = pc; ghr_in = g; upd_en = ue; upd_idx = ui; upd_taken = ut; upd_pred = up;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("arst_valid", pred_valid, 0);
    chk("arst_taken", pred_taken, 0);
    chk("arst_idx", pred_idx, 0);
    chk("arst_gu", ghr_update_en, 0);
    chk("arst_gb", ghr_in_bit, 0);
    chk("arst_cnt", cnt, 0);
    #1 reset = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk) reset = 1;
    #1;
    chk("rst_valid", pred_valid, 0);
    chk("rst_cnt", cnt, 0);
    step(1, 8'h10, 3'b000, 0, 0, 0, 0);
    chk("lk_valid", pred_valid, 1);
    chk("lk_idx", pred_idx, 3'b100);
    chk("lk_taken", pred_taken, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 8'h0C, 3'b000, 1, 3, 1, 1);
      chk("trn_taken", pred_taken, k > 0);
    end
    step(1, 8'h0C, 3'b000, 0, 0, 0, 0);
    chk("trn_sat", pred_taken, 1);
    repeat (3) step(0, 0, 0, 1, 3, 0, 0);
    step(1, 8'h0C, 3'b000, 0, 0, 0, 0);
    chk("trn_low", pred_taken, 0);
    step(1, 8'h14, 3'b000, 1, 5, 1, 1);
    chk("rbw_same", pred_taken, 0);
    step(1, 8'h14, 3'b000, 0, 0, 0, 0);
    chk("rbw_next", pred_taken, 1);
    pulse();
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i * 4), 3'b000, 0, 0, 0, 0);
      chk("init_taken", pred_taken, 0);
    end
    step(0, 0, 0, 1, 2, 1, 1);
    chk("hist_gu1", ghr_update_en, 1);
    chk("hist_gb1", ghr_in_bit, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hist_gu0", ghr_update_en, 0);
    chk("hist_gb_hold", ghr_in_bit, 1);
    chk("hist_reg", hist, 3'b001);
    pulse();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 1, 0, 1);
      chk("mp_cnt2", s_cnt, (k < 2) ? k + 1 : 3);
      chk("mp_cnt", cnt, k + 1);
    end
    step(0, 0, 0, 1, 1, 1, 1);
    chk("mp_cnt2_hold", s_cnt, 3);
    chk("mp_cnt_hold", cnt, 5);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      lookup_en = 1'($urandom); lookup_pc = 8'($urandom); ghr_in = 3'($urandom);
      upd_en = 1'($urandom); upd_idx = 3'($urandom); upd_taken = 1'($urandom); upd_pred = 1'($urandom);
      if ($urandom_range(0, 199) == 0) pulse();
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
